evt_xfer_sched: RTL and testbench

- Scheduler that shares one destination register among three event sources.
- Sources: rising edge of ev_a, rising edge of ev_b, and any level change of trig while enable is high.
- Each detected event is queued in a per-source pending counter. Round-robin arbitration grants one transfer at a time into dout, followed by a programmable hold window.
- Sits between asynchronous-style event producers and a shared capture register; it sequences the loads.

---
 rtl/evt_xfer_sched.sv | 95 +++++++++
 tb/tb_evt_xfer_sched.sv | 135 +++++++++++++
 2 files changed

// File: rtl/evt_xfer_sched.sv
// evt_xfer_sched: round-robin scheduler loading one shared register from three event sources.
// Optional EVT_XFER_SCHED_STAMP_EN adds a free-running cycle counter captured into stamp per grant.
module evt_xfer_sched #(
  parameter int WIDTH = 8,
  parameter int HOLD = 2,
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic rst,
  input logic enable,
  input logic trig,
  input logic ev_a,
  input logic ev_b,
  input logic [WIDTH-1:0] din_a,
  input logic [WIDTH-1:0] din_b,
  output logic [WIDTH-1:0] dout,
  output logic load,
  output logic [1:0] src,
  output logic busy,
  output logic overflow
`ifdef EVT_XFER_SCHED_STAMP_EN
  ,
  output logic [15:0] stamp
`endif
);
  localparam int HW = HOLD > 0 ? $clog2(HOLD + 1) : 1;
  typedef enum logic {S_IDLE, S_HOLD} state_t;
  state_t state, state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [1:0] rr_last, sel;
  logic ev_a_q, ev_b_q, trig_q;
  logic [CNT_W-1:0] pend [3];
  logic [2:0] inc, req, sat, gnt;
  logic gnt_en;
  assign inc = {enable & (trig ^ trig_q), ev_b & ~ev_b_q, ev_a & ~ev_a_q};
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == S_IDLE ? (gnt_en && HOLD > 0 ? S_HOLD : S_IDLE)
                                : (hold_cnt == HW'(1) ? S_IDLE : S_HOLD);
  // Fallback to rr_last is only reached when it is the sole requester.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      req[i] = pend[i] != '0;
      sat[i] = &pend[i];
    end
    gnt_en = state == S_IDLE && |req;
    sel = rr_last == 2'd0 ? (req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd0) :
          rr_last == 2'd1 ? (req[2] ? 2'd2 : req[0] ? 2'd0 : 2'd1) :
                            (req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd2);
    gnt = gnt_en ? 3'b001 << sel : 3'b000;
  end
  always_ff @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (rst) pend[i] <= '0;
      else if (inc[i] && !gnt[i] && !sat[i]) pend[i] <= pend[i] + 1'b1;
      else if (gnt[i] && !inc[i]) pend[i] <= pend[i] - 1'b1;
  always_ff @(posedge clk)
    if (rst) begin
      dout <= '0;
      load <= 1'b0;
      src <= 2'd0;
      busy <= 1'b0;
      overflow <= 1'b0;
      hold_cnt <= '0;
      rr_last <= 2'd2;
      {ev_a_q, ev_b_q, trig_q} <= 3'b000;
    end else begin
      {ev_a_q, ev_b_q, trig_q} <= {ev_a, ev_b, trig};
      overflow <= overflow | |(inc & ~gnt & sat);
      load <= gnt_en;
      if (gnt_en) begin
        dout <= sel == 2'd0 ? din_a : din_b;
        src <= sel;
        rr_last <= sel;
        hold_cnt <= HW'(HOLD);
        busy <= HOLD > 0;
      end else if (state == S_HOLD) begin
        hold_cnt <= hold_cnt - 1'b1;
        busy <= hold_cnt != HW'(1);
      end
    end
`ifdef EVT_XFER_SCHED_STAMP_EN
  logic [15:0] cyc;
  always_ff @(posedge clk)
    if (rst) begin
      cyc <= '0;
      stamp <= '0;
    end else begin
      cyc <= cyc + 1'b1;
      if (gnt_en) stamp <= cyc;
    end
`endif
endmodule

// File: tb/tb_evt_xfer_sched.sv
// tb_evt_xfer_sched: two instances (HOLD=2 and HOLD=0) checked every cycle against a queue-level model.
module tb_evt_xfer_sched;
  logic clk = 0, rst = 1, enable = 0, trig = 0, ev_a = 0, ev_b = 0;
  logic [7:0] din_a = 0, din_b = 0;
  logic [7:0] dout [2];
  logic load [2], busy [2], ovf [2];
  logic [1:0] src [2];
  int errors = 0, checks = 0;
  int pend [2][3];
  int hl [2], rr [2];
  logic [7:0] md [2];
  logic [1:0] ms [2];
  logic ml [2], mb [2], mo [2], qa [2], qb [2], qt [2];
`ifdef EVT_XFER_SCHED_STAMP_EN
  logic [15:0] stamp [2];
`endif

  always #5 clk = ~clk;

  evt_xfer_sched #(.WIDTH(8), .HOLD(2), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .trig(trig), .ev_a(ev_a), .ev_b(ev_b),
    .din_a(din_a), .din_b(din_b), .dout(dout[0]), .load(load[0]), .src(src[0]),
    .busy(busy[0]), .overflow(ovf[0])
`ifdef EVT_XFER_SCHED_STAMP_EN
    , .stamp(stamp[0])
`endif
  );
  evt_xfer_sched #(.WIDTH(8), .HOLD(0), .CNT_W(3)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .trig(trig), .ev_a(ev_a), .ev_b(ev_b),
    .din_a(din_a), .din_b(din_b), .dout(dout[1]), .load(load[1]), .src(src[1]),
    .busy(busy[1]), .overflow(ovf[1])
`ifdef EVT_XFER_SCHED_STAMP_EN
    , .stamp(stamp[1])
`endif
  );

  // One clock of the reference: choose a grant from the old queue depths, then enqueue events.
  task automatic step(input int m, input int h);
    int ev [3];
    int g;
    if (rst) begin
      for (int s = 0; s < 3; s++) pend[m][s] = 0;
      hl[m] = 0; rr[m] = 2; md[m] = 0; ms[m] = 0;
      ml[m] = 0; mb[m] = 0; mo[m] = 0; qa[m] = 0; qb[m] = 0; qt[m] = 0;
      return;
    end
    ev[0] = int'(ev_a && !qa[m]);
    ev[1] = int'(ev_b && !qb[m]);
    ev[2] = int'(enable && (trig != qt[m]));
    g = -1;
    if (hl[m] == 0)
      for (int k = 1; k <= 3; k++)
        if (g < 0 && pend[m][(rr[m] + k) % 3] > 0) g = (rr[m] + k) % 3;
    ml[m] = 0;
    if (g >= 0) begin
      md[m] = g == 0 ? din_a : din_b;
      ms[m] = 2'(g);
      ml[m] = 1;
      rr[m] = g;
      if (h > 0) begin hl[m] = h; mb[m] = 1; end
    end else if (hl[m] > 0) begin
      hl[m]--;
      if (hl[m] == 0) mb[m] = 0;
    end
    for (int s = 0; s < 3; s++)
      if (ev[s] == 1 && g != s) begin
        if (pend[m][s] == 7) mo[m] = 1;
        else pend[m][s]++;
      end else if (ev[s] == 0 && g == s) pend[m][s]--;
    qa[m] = ev_a; qb[m] = ev_b; qt[m] = trig;
  endtask

  task automatic chk(input string tag, input int m, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[%0d] got=%0h exp=%0h t=%0t", tag, m, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic en, input logic tg, input logic a, input logic b,
                     input logic [7:0] da, input logic [7:0] db);
    rst = r; enable = en; trig = tg; ev_a = a; ev_b = b; din_a = da; din_b = db;
    @(posedge clk);
    step(0, 2);
    step(1, 0);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("dout", m, dout[m], md[m]);
      chk("load", m, {7'd0, load[m]}, {7'd0, ml[m]});
      chk("src", m, {6'd0, src[m]}, {6'd0, ms[m]});
      chk("busy", m, {7'd0, busy[m]}, {7'd0, mb[m]});
      chk("overflow", m, {7'd0, ovf[m]}, {7'd0, mo[m]});
    end
  endtask

  initial begin
    // Reset with ev_a held high: the edge is seen right after release.
    cyc(1, 0, 0, 1, 0, 8'h5A, 8'h33);
    cyc(1, 0, 0, 1, 0, 8'h5A, 8'h33);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 8'h5A, 8'h33);
    // Single A event.
    cyc(0, 0, 0, 0, 0, 8'h5A, 8'h33);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, 8'h5A, 8'h33);
    // Simultaneous A, B, T.
    cyc(0, 1, 0, 0, 0, 8'h5A, 8'h33);
    for (int i = 0; i < 12; i++) cyc(0, 1, 1, 1, 1, 8'h5A, 8'h33);
    // trig toggling while disabled.
    for (int i = 0; i < 8; i++) cyc(0, 0, logic'(i % 2), 0, 0, 8'h11, 8'h22);
    // Burst of A edges outpacing the HOLD=2 instance's grant rate.
    for (int i = 0; i < 60; i++) cyc(0, 0, 0, logic'(i % 2), 0, 8'(i), 8'h44);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0, 0, 8'hA5, 8'h44);
    checks++;
    assert (ovf[0] === 1'b1) else begin
      errors++;
      $error("FAIL sticky_overflow got=%0b exp=1", ovf[0]);
    end
    // Two A and one B queued on the HOLD=0 instance.
    cyc(0, 0, 0, 1, 1, 8'h01, 8'h02);
    cyc(0, 0, 0, 0, 0, 8'h03, 8'h04);
    cyc(0, 0, 0, 1, 0, 8'h05, 8'h06);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 8'h07, 8'h08);
    // Reset in the middle of a hold window with events pending.
    cyc(0, 1, 1, 1, 1, 8'h77, 8'h88);
    cyc(0, 1, 0, 1, 1, 8'h77, 8'h88);
    cyc(1, 1, 0, 1, 1, 8'h77, 8'h88);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 8'h99, 8'hAA);
    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      cyc(logic'($urandom_range(63) == 0), logic'($urandom), logic'($urandom),
          logic'($urandom), logic'($urandom), 8'($urandom), 8'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
